// File: rtl/e_mdu.sv
// ----------------------------------------------------------------------------
// e_mdu -- multi-cycle multiply/divide unit for the EX stage.
//
// Executes MULT/MULTU/DIV/DIVU into a HI/LO register pair and handles
// MTHI/MTLO writes. The arithmetic result is computed combinationally
// when the op is accepted and parked in pending registers. Busy is held
// for a fixed per-op number of cycles, then HI/LO are committed and Done
// pulses for one cycle. The hazard unit stalls on Busy.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   Start    in   op strobe, sampled on rising clk
//   MDU_Op   in   [2:0] 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU,
//                       101 MTHI, 110 MTLO, 111 reserved
//   SrcA     in   [WIDTH-1:0] rs operand / dividend / MTHI-MTLO data
//   SrcB     in   [WIDTH-1:0] rt operand / divisor
//   Busy     out  arithmetic op in flight
//   Done     out  one-cycle pulse when HI/LO were just committed
//   HI, LO   out  [WIDTH-1:0] result registers
// ----------------------------------------------------------------------------
module e_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Start,
    input  logic [2:0]       MDU_Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_phi;
    logic [WIDTH-1:0]   r_plo;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    // ------------------------------------------------------------------
    // Combinational arithmetic on the live operands
    // ------------------------------------------------------------------
    logic signed [2*WIDTH-1:0] w_prod_s;
    logic        [2*WIDTH-1:0] w_prod_u;
    logic                      w_b_zero;
    logic        [WIDTH-1:0]   w_abs_a;
    logic        [WIDTH-1:0]   w_abs_b;
    logic        [WIDTH-1:0]   w_udiv_den;
    logic        [WIDTH-1:0]   w_sdiv_den;
    logic        [WIDTH-1:0]   w_uq;
    logic        [WIDTH-1:0]   w_ur;
    logic        [WIDTH-1:0]   w_mq;
    logic        [WIDTH-1:0]   w_mr;
    logic        [WIDTH-1:0]   w_sq;
    logic        [WIDTH-1:0]   w_sr;

    assign w_prod_s = $signed({{WIDTH{SrcA[WIDTH-1]}}, SrcA})
                    * $signed({{WIDTH{SrcB[WIDTH-1]}}, SrcB});
    assign w_prod_u = {{WIDTH{1'b0}}, SrcA} * {{WIDTH{1'b0}}, SrcB};

    assign w_b_zero = (SrcB == '0);

    // Signed divide works on magnitudes. |MIN_NEG| wraps to 2^(WIDTH-1),
    // which is exactly right as an unsigned magnitude, and negating that
    // quotient yields MIN_NEG again -- so MIN_NEG / -1 falls out as
    // LO=MIN_NEG, HI=0 without a special case.
    assign w_abs_a = SrcA[WIDTH-1] ? -SrcA : SrcA;
    assign w_abs_b = SrcB[WIDTH-1] ? -SrcB : SrcB;

    // Divisor is forced to 1 when zero so the dividers never see /0;
    // the zero-divisor result is substituted below anyway.
    assign w_udiv_den = w_b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : SrcB;
    assign w_sdiv_den = w_b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : w_abs_b;

    assign w_uq = SrcA / w_udiv_den;
    assign w_ur = SrcA % w_udiv_den;
    assign w_mq = w_abs_a / w_sdiv_den;
    assign w_mr = w_abs_a % w_sdiv_den;

    // Quotient truncates toward zero; remainder follows dividend sign.
    assign w_sq = (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]) ? -w_mq : w_mq;
    assign w_sr = SrcA[WIDTH-1] ? -w_mr : w_mr;

    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;
    logic             w_is_arith;
    logic [CNT_W-1:0] w_cycles;

    always_comb begin
        w_res_hi   = '0;
        w_res_lo   = '0;
        w_is_arith = 1'b0;
        w_cycles   = CNT_W'(MULT_CYCLES);
        case (MDU_Op)
            OP_MULT: begin
                w_is_arith = 1'b1;
                {w_res_hi, w_res_lo} = w_prod_s;
            end
            OP_MULTU: begin
                w_is_arith = 1'b1;
                {w_res_hi, w_res_lo} = w_prod_u;
            end
            OP_DIV: begin
                w_is_arith = 1'b1;
                w_cycles   = CNT_W'(DIV_CYCLES);
                w_res_hi   = w_b_zero ? SrcA : w_sr;
                w_res_lo   = w_b_zero ? '1   : w_sq;
            end
            OP_DIVU: begin
                w_is_arith = 1'b1;
                w_cycles   = CNT_W'(DIV_CYCLES);
                w_res_hi   = w_b_zero ? SrcA : w_ur;
                w_res_lo   = w_b_zero ? '1   : w_uq;
            end
            default: begin
                w_is_arith = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_phi   <= '0;
            r_plo   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (Start) begin
                    if (w_is_arith) begin
                        r_phi   <= w_res_hi;
                        r_plo   <= w_res_lo;
                        r_cnt   <= w_cycles;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else if (MDU_Op == OP_MTHI) begin
                        r_hi <= SrcA;
                    end else if (MDU_Op == OP_MTLO) begin
                        r_lo <= SrcA;
                    end
                end
            end else begin
                // Start is ignored entirely while running.
                if (r_cnt == CNT_W'(1)) begin
                    r_hi    <= r_phi;
                    r_lo    <= r_plo;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
        end
    end

    assign Busy = r_busy;
    assign Done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// ----------------------------------------------------------------------------
// tb_e_mdu -- self-checking bench for e_mdu (default 32-bit parameters).
//
// A behavioural reference model tracks the expected HI/LO/Busy/Done from
// the op semantics: results are computed with 64-bit integer arithmetic at
// accept time and committed at an absolute edge number (accept edge + N).
// A single model/compare process checks every cycle; directed sequences
// add hand-computed literal expectations, then a randomized phase drives
// arbitrary ops every cycle, including while busy.
// ----------------------------------------------------------------------------
module tb_e_mdu;

    logic        clk;
    logic        reset_n;
    logic        Start;
    logic [2:0]  MDU_Op;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    e_mdu #(
        .WIDTH      (32),
        .MULT_CYCLES(5),
        .DIV_CYCLES (10),
        .CNT_W      (4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .Start  (Start),
        .MDU_Op (MDU_Op),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .Busy   (Busy),
        .Done   (Done),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_result(input logic [2:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [31:0] q32;
        logic [31:0] r32;
        logic [63:0] res;
        sa  = $signed(a);
        sb  = $signed(b);
        res = 64'd0;
        case (op)
            3'd1: res = sa * sb;
            3'd2: res = {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    q32 = q[31:0];
                    r32 = r[31:0];
                    res = {r32, q32};
                end
            end
            3'd4: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [63:0] m_pend = '0;
    longint      m_edge = 0;
    longint      m_commit_edge = 0;

    task automatic model_reset();
        m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_pend = '0;
    endtask

    task automatic model_step();
        m_edge++;
        m_done = 1'b0;
        if (m_busy) begin
            if (m_edge == m_commit_edge) begin
                {m_hi, m_lo} = m_pend;
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else if (Start) begin
            if (MDU_Op >= 3'd1 && MDU_Op <= 3'd4) begin
                m_pend        = ref_result(MDU_Op, SrcA, SrcB);
                m_commit_edge = m_edge + ((MDU_Op <= 3'd2) ? 5 : 10);
                m_busy        = 1'b1;
            end else if (MDU_Op == 3'd5) m_hi = SrcA;
            else if (MDU_Op == 3'd6) m_lo = SrcA;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!reset_n) model_reset();
            else model_step();
            @(negedge clk);
            if (!reset_n) model_reset();
            check("cyc_busy", 64'(Busy), 64'(m_busy));
            check("cyc_done", 64'(Done), 64'(m_done));
            check("cyc_hi",   64'(HI),   64'(m_hi));
            check("cyc_lo",   64'(LO),   64'(m_lo));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cnt);
        Start = 1'b1; MDU_Op = op; SrcA = a; SrcB = b;
        @(posedge clk); #1;
        Start = 1'b0; MDU_Op = 3'd0; SrcA = $urandom; SrcB = $urandom;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Busy) busy_cnt++;
            if (Done) return;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout op=%0d actual=no Done required=Done within 40 cycles", op);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    int n;

    initial begin
        reset_n = 1'b0; Start = 1'b0; MDU_Op = 3'd0; SrcA = '0; SrcB = '0;

        // Pin the reference model with hand-computed values.
        check("ref_mult",    ref_result(3'd1, 32'hFFFF_FFFD, 32'd5),         64'hFFFF_FFFF_FFFF_FFF1);
        check("ref_multu",   ref_result(3'd2, 32'hFFFF_FFFF, 32'd2),         64'h0000_0001_FFFF_FFFE);
        check("ref_divu",    ref_result(3'd4, 32'd100, 32'd7),               64'h0000_0002_0000_000E);
        check("ref_div",     ref_result(3'd3, 32'hFFFF_FFF9, 32'd2),         64'hFFFF_FFFF_FFFF_FFFD);
        check("ref_div_ovf", ref_result(3'd3, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
        check("ref_divu_z",  ref_result(3'd4, 32'd5, 32'd0),                 64'h0000_0005_FFFF_FFFF);

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_hi",   64'(HI),   64'd0);
        check("rst_lo",   64'(LO),   64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // MULT -3 * 5
        run_op(3'd1, 32'hFFFF_FFFD, 32'd5, n);
        check("mult_busy_len", 64'(n), 64'd5);
        check("mult_hi", 64'(HI), 64'hFFFF_FFFF);
        check("mult_lo", 64'(LO), 64'hFFFF_FFF1);

        // MULTU then DIVU issued in the Done cycle
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, n);
        check("multu_hi", 64'(HI), 64'h0000_0001);
        check("multu_lo", 64'(LO), 64'hFFFF_FFFE);
        run_op(3'd4, 32'd100, 32'd7, n);
        check("divu_busy_len", 64'(n), 64'd10);
        check("divu_hi", 64'(HI), 64'd2);
        check("divu_lo", 64'(LO), 64'd14);

        // Signed divide and boundary cases
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, n);
        check("div_hi", 64'(HI), 64'hFFFF_FFFF);
        check("div_lo", 64'(LO), 64'hFFFF_FFFD);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
        check("div_ovf_hi", 64'(HI), 64'd0);
        check("div_ovf_lo", 64'(LO), 64'h8000_0000);
        run_op(3'd4, 32'd5, 32'd0, n);
        check("divu_z_hi", 64'(HI), 64'd5);
        check("divu_z_lo", 64'(LO), 64'hFFFF_FFFF);

        // DIV 1000 / -3 with MTHI and MULT strobed while busy
        Start = 1'b1; MDU_Op = 3'd3; SrcA = 32'd1000; SrcB = 32'hFFFF_FFFD;
        @(posedge clk); #1;
        Start = 1'b0; SrcA = $urandom; SrcB = $urandom;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (Busy) n++;
            if (Done) break;
            if (i == 1) begin Start = 1'b1; MDU_Op = 3'd5; SrcA = 32'h1234; end
            if (i == 2) begin Start = 1'b1; MDU_Op = 3'd1; SrcA = 32'd3; SrcB = 32'd3; end
            if (i == 3) begin Start = 1'b0; MDU_Op = 3'd0; end
        end
        check("div_intr_busy_len", 64'(n), 64'd10);
        check("div_intr_done", 64'(Done), 64'd1);
        check("div_intr_hi", 64'(HI), 64'd1);
        check("div_intr_lo", 64'(LO), 64'hFFFF_FEB3);

        // MTHI then MTLO in consecutive cycles
        Start = 1'b1; MDU_Op = 3'd5; SrcA = 32'hAAAA_5555;
        @(negedge clk);
        check("mthi_hi", 64'(HI), 64'hAAAA_5555);
        check("mthi_busy", 64'(Busy), 64'd0);
        MDU_Op = 3'd6; SrcA = 32'h0F0F_0F0F;
        @(negedge clk);
        check("mtlo_lo", 64'(LO), 64'h0F0F_0F0F);
        check("mtlo_hi", 64'(HI), 64'hAAAA_5555);
        check("mtlo_busy", 64'(Busy), 64'd0);
        check("mtlo_done", 64'(Done), 64'd0);
        Start = 1'b0; MDU_Op = 3'd0;

        // Asynchronous reset in the middle of a MULT
        @(negedge clk);
        Start = 1'b1; MDU_Op = 3'd1; SrcA = 32'd7; SrcB = 32'd9;
        @(posedge clk); #1;
        Start = 1'b0; MDU_Op = 3'd0;
        @(posedge clk);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", 64'(Busy), 64'd0);
        check("arst_done", 64'(Done), 64'd0);
        check("arst_hi",   64'(HI),   64'd0);
        check("arst_lo",   64'(LO),   64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("post_rst_done", 64'(Done), 64'd0);
            check("post_rst_hi",   64'(HI),   64'd0);
            check("post_rst_lo",   64'(LO),   64'd0);
        end

        // Randomized ops every cycle, including while busy
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            Start  = ($urandom_range(0, 3) != 0);
            MDU_Op = 3'($urandom_range(0, 7));
            SrcA   = pick_val();
            SrcB   = pick_val();
        end
        @(negedge clk);
        Start = 1'b0; MDU_Op = 3'd0;
        repeat (14) @(negedge clk);
        check("final_idle", 64'(Busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
Parametrised multi-cycle multiply/divide unit in the EX stage, alongside the E-stage ALU. It executes signed and unsigned multiply and divide into a HI/LO register pair, and also handles MTHI/MTLO writes. It models fixed multi-cycle latency with a Busy flag, which the hazard unit uses to stall HI/LO-dependent instructions. Width and latencies are parameters, for reuse beyond the 32-bit datapath.

Parameters:
WIDTH, 32, operand/HI/LO width in bits (>=2)
MULT_CYCLES, 5, Busy cycles for MULT/MULTU (>=1)
DIV_CYCLES, 10, Busy cycles for DIV/DIVU (>=1)
CNT_W, 4, countdown counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
Start  input  1  op strobe, sampled on rising clk
MDU_Op  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved
SrcA  input  WIDTH  rs operand / dividend / MTHI-MTLO data
SrcB  input  WIDTH  rt operand / divisor
Busy  output  1  arithmetic op in flight
Done  output  1  one-cycle pulse; HI/LO just committed by MULT/DIV
HI  output  WIDTH  HI register
LO  output  WIDTH  LO register

Behaviour:
- Reset (reset_n=0, asynchronous): Busy=0, Done=0, HI=0, LO=0, counter=0, state IDLE, pending results=0. Deassertion is synchronous to clk (external synchroniser).
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1, counter counting down.
- IDLE, Start=1, op in 001..100:
  - Compute the result combinationally from SrcA/SrcB.
  - Latch it into pending regs PHI/PLO.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
  - HI/LO are unchanged until commit.
- RUN: decrement counter each edge. On the edge where the counter would reach 0:
  - HI<=PHI, LO<=PLO.
  - Busy<=0, Done<=1 for exactly one cycle.
  - Go to IDLE.
- Busy stays high for exactly N cycles after the accept edge, where N is the parameter for the op.
- Back-to-back ops: a new Start in the same cycle Done=1 is accepted normally.
- IDLE, Start=1, MTHI: HI<=SrcA on that edge. MTLO: LO<=SrcA. No Busy, no Done.
- Start=1 with op 000 or 111: no effect.
- Start=1 while Busy=1 (any op, including MTHI/MTLO): ignored entirely. In-flight op and HI/LO are unaffected; the stall unit guarantees this does not occur.
- Arithmetic:
  - MULT: signed WIDTH×WIDTH product, 2·WIDTH bits; HI=upper, LO=lower.
  - MULTU: unsigned product, same split.
  - DIV: signed; quotient truncates toward zero; LO=quotient, HI=remainder. Remainder sign equals dividend sign.
  - DIV overflow, MIN_NEG / -1: LO=MIN_NEG, HI=0.
  - DIVU: unsigned; LO=quotient, HI=remainder.
  - Divide by zero (DIV or DIVU): LO=all ones, HI=SrcA. Normal latency, no exception.
- Operands are captured only on the accept edge; later SrcA/SrcB changes have no effect.
- Reset asserted mid-operation aborts the op immediately. Outputs go to reset values and the pending result is discarded.

Test Plan:
- MULT SrcA=0xFFFFFFFD (-3), SrcB=5 -> Busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1, Done pulse 1 cycle; HI/LO hold old values during Busy.
- MULTU 0xFFFFFFFF×2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles. Immediately followed by DIVU 100/7 in the Done cycle -> accepted; after 10 cycles LO=14, HI=2.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
- During a DIV, pulse Start with MTHI SrcA=0x1234 and with MULT -> both ignored; final HI/LO equal the DIV result; Busy duration unchanged at 10.
- MTHI 0xAAAA5555 then MTLO 0x0F0F0F0F in consecutive cycles -> HI/LO update on each accept edge, Busy and Done stay 0.
- Assert reset_n=0 asynchronously mid-MULT (cycle 3) -> Busy, Done, HI, LO go to 0 without a clock edge. After release, no stale Done and no HI/LO update.
